sm3_msg_feeder: RTL and testbench

Byte-stream front end for the SM3 core. It packs host bytes big-endian into `INPT_DW`-bit message words and buffers them in a word FIFO. It drives the core's message-input handshake (data, byte-valid mask, valid, last; the core returns ready). It also captures the core's 256-bit digest and returns it to the host as eight 32-bit words over a valid/ready stream, one message in flight at a time.

---
 rtl/sm3_msg_feeder.sv | 162 ++++++++++++++++
 tb/tb_sm3_msg_feeder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_feeder.sv
// rtl/sm3_msg_feeder.sv - byte packer, message word FIFO and digest return path for an SM3 core
module sm3_msg_feeder #(
  parameter int INPT_DW    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_d,
  input  logic                 byte_vld,
  input  logic                 byte_lst,
  output logic                 byte_rdy,
  output logic [INPT_DW-1:0]   msg_d,
  output logic [INPT_DW/8-1:0] msg_vld_byte,
  output logic                 msg_vld,
  output logic                 msg_lst,
  input  logic                 msg_rdy,
  input  logic [255:0]         res_d,
  input  logic                 res_vld,
  output logic [31:0]          dgst_d,
  output logic                 dgst_vld,
  output logic                 dgst_lst,
  input  logic                 dgst_rdy,
  output logic                 err
);

  localparam int NB = INPT_DW / 8;
  localparam int KW = $clog2(NB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = INPT_DW + NB + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {LOAD, WAIT_RES, DGST} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [INPT_DW-1:0]  pack_q, pack_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                byte_rdy_q, byte_rdy_d;
  logic [255:0]        dig_q, dig_d;
  logic [2:0]          idx_q, idx_d;
  logic                err_q, err_d;

  logic                byte_acc, push, pop;
  logic [INPT_DW-1:0]  word_w;
  logic [NB-1:0]       mask_w;
  logic [EW-1:0]       head_w;

  assign byte_acc = byte_vld & byte_rdy_q;
  assign push     = byte_acc & ((k_q == KW'(NB-1)) | byte_lst);
  assign msg_vld  = (cnt_q != '0);
  assign pop      = msg_vld & msg_rdy;
  assign head_w   = mem_q[rd_q];

  // Merge the incoming byte into its big-endian lane and build the leading-ones mask.
  always_comb begin
    word_w = pack_q;
    mask_w = '0;
    for (int j = 0; j < NB; j++) begin
      if (KW'(j) == k_q) word_w[INPT_DW-1-8*j -: 8] = byte_d;
      mask_w[NB-1-j] = (KW'(j) <= k_q);
    end
  end

  // Next-state for packer, FIFO pointers and occupancy.
  always_comb begin
    pack_d = pack_q;
    k_d    = k_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (byte_acc) begin
      pack_d = push ? '0 : word_w;
      k_d    = push ? '0 : k_q + KW'(1);
    end
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control FSM: message load, digest wait, digest return; flags misplaced digest pulses.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      LOAD: begin
        if (byte_acc && byte_lst) state_d = WAIT_RES;
        if (res_vld) err_d = 1'b1;
      end
      WAIT_RES: begin
        if (res_vld) begin
          if (cnt_q == '0) begin
            dig_d   = res_d;
            idx_d   = 3'd0;
            state_d = DGST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DGST: begin
        if (dgst_rdy) begin
          dig_d = {dig_q[223:0], 32'h0};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = LOAD;
        end
        if (res_vld) err_d = 1'b1;
      end
      default: state_d = LOAD;
    endcase
    byte_rdy_d = (state_d == LOAD) && (cnt_d != FULL_CNT);
  end

  // Control and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      k_q        <= '0;
      pack_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      byte_rdy_q <= 1'b1;
      dig_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pack_q     <= pack_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      byte_rdy_q <= byte_rdy_d;
      dig_q      <= dig_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage; contents are only observed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {byte_lst, mask_w, word_w};
  end

  assign byte_rdy     = byte_rdy_q;
  assign msg_d        = msg_vld ? head_w[INPT_DW-1:0] : '0;
  assign msg_vld_byte = msg_vld ? head_w[INPT_DW +: NB] : '0;
  assign msg_lst      = msg_vld & head_w[EW-1];
  assign dgst_vld     = (state_q == DGST);
  assign dgst_d       = dgst_vld ? dig_q[255:224] : 32'h0;
  assign dgst_lst     = dgst_vld & (idx_q == 3'd7);
  assign err          = err_q;

endmodule

// File: tb/tb_sm3_msg_feeder.sv
// tb/tb_sm3_msg_feeder.sv - self-checking bench for sm3_msg_feeder (32- and 64-bit word instances in lockstep)
module tb_sm3_msg_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [7:0]   byte_d;
  logic         byte_vld, byte_lst, byte_rdy;
  logic [255:0] res_d;
  logic         res_vld, dgst_rdy;

  logic [31:0]  msg_d32;
  logic [3:0]   msk32;
  logic         msg_vld32, msg_lst32;
  logic         msg_rdy32 = 1'b0;
  logic [31:0]  dgst_d32;
  logic         dgst_vld32, dgst_lst32, err32;

  logic         byte_vld64, byte_rdy64;
  logic [63:0]  msg_d64;
  logic [7:0]   msk64;
  logic         msg_vld64, msg_lst64;
  logic         msg_rdy64 = 1'b0;
  logic [31:0]  dgst_d64;
  logic         dgst_vld64, dgst_lst64, err64;

  assign byte_vld64 = byte_vld & byte_rdy;

  sm3_msg_feeder #(.INPT_DW(32), .FIFO_DEPTH(8)) dut32 (
    .clk(clk), .rst(rst), .byte_d(byte_d), .byte_vld(byte_vld), .byte_lst(byte_lst),
    .byte_rdy(byte_rdy), .msg_d(msg_d32), .msg_vld_byte(msk32), .msg_vld(msg_vld32),
    .msg_lst(msg_lst32), .msg_rdy(msg_rdy32), .res_d(res_d), .res_vld(res_vld),
    .dgst_d(dgst_d32), .dgst_vld(dgst_vld32), .dgst_lst(dgst_lst32), .dgst_rdy(dgst_rdy),
    .err(err32));

  sm3_msg_feeder #(.INPT_DW(64), .FIFO_DEPTH(8)) dut64 (
    .clk(clk), .rst(rst), .byte_d(byte_d), .byte_vld(byte_vld64), .byte_lst(byte_lst),
    .byte_rdy(byte_rdy64), .msg_d(msg_d64), .msg_vld_byte(msk64), .msg_vld(msg_vld64),
    .msg_lst(msg_lst64), .msg_rdy(msg_rdy64), .res_d(res_d), .res_vld(res_vld),
    .dgst_d(dgst_d64), .dgst_vld(dgst_vld64), .dgst_lst(dgst_lst64), .dgst_rdy(dgst_rdy),
    .err(err64));

  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
    logic        l;
  } exp_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          rdy_mode = 1;
  logic [7:0]  msg_q[$];
  exp_t        e32_q[$];
  exp_t        e64_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: chop the message into word-sized chunks, big-endian, mask = bytes present.
  task automatic model_push();
    int n;
    int nb;
    exp_t e;
    n = msg_q.size();
    for (int w = 0; w < 2; w++) begin
      nb = (w == 0) ? 4 : 8;
      for (int c = 0; c < n; c += nb) begin
        e.d = 64'h0;
        e.m = 8'h0;
        for (int j = 0; j < nb; j++) begin
          if (c + j < n) begin
            e.d = e.d | (64'(msg_q[c+j]) << (8 * (nb - 1 - j)));
            e.m = e.m | (8'(1) << (nb - 1 - j));
          end
        end
        e.l = (c + nb >= n);
        if (nb == 4) e32_q.push_back(e);
        else e64_q.push_back(e);
      end
    end
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_range(input int from, input int to, input int budget, output int sent);
    bit acc;
    int cyc;
    sent = 0;
    for (int i = from; i < to; i++) begin
      byte_d   = msg_q[i];
      byte_lst = (i == msg_q.size() - 1);
      byte_vld = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < budget) begin
        @(negedge clk);
        if (byte_rdy) begin
          acc = 1'b1;
          chk("lockstep_rdy64", byte_rdy64, 1);
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) break;
      sent++;
    end
    byte_vld = 1'b0;
    byte_lst = 1'b0;
  endtask

  task automatic pulse_res(input logic [255:0] d);
    int cyc;
    cyc = 0;
    while ((msg_vld32 || msg_vld64) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("fifo_drain", msg_vld32 | msg_vld64, 0);
    res_d   = d;
    res_vld = 1'b1;
    @(posedge clk);
    #1;
    res_vld = 1'b0;
    @(negedge clk);
    chk("dgst_vld_n1", dgst_vld32, 1);
    chk("dgst_w0_n1", dgst_d32, d[255:224]);
    chk("byte_rdy_dgst", byte_rdy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic get_digest(input logic [255:0] d, input int style, input int stop_at,
                            output int stopped);
    bit done;
    int cyc;
    logic [31:0] w;
    stopped = 0;
    for (int i = 0; i < 8; i++) begin
      w = d[255 - 32*i -: 32];
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin
        if (style == 0) dgst_rdy = (cyc % 2 == 1);
        else dgst_rdy = (cyc >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("dgst_vld", dgst_vld32, 1);
        chk("dgst_d", dgst_d32, w);
        chk("dgst_lst", dgst_lst32, (i == 7));
        chk("dgst64_d", dgst_d64, w);
        if (dgst_rdy) begin
          if (i == stop_at) begin
            stopped = 1;
            break;
          end
          done = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      if (stopped != 0) break;
      chk("dgst_progress", done, 1);
    end
    if (stopped == 0) begin
      dgst_rdy = 1'b0;
      @(negedge clk);
      chk("byte_rdy_after_dgst", byte_rdy, 1);
      chk("dgst_vld_after", dgst_vld32, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_byte_rdy"}, byte_rdy, 1);
    chk({tag, "_msg_vld"}, msg_vld32, 0);
    chk({tag, "_msg_lst"}, msg_lst32, 0);
    chk({tag, "_msg_d"}, msg_d32, 0);
    chk({tag, "_mask"}, msk32, 0);
    chk({tag, "_dgst_vld"}, dgst_vld32, 0);
    chk({tag, "_dgst_lst"}, dgst_lst32, 0);
    chk({tag, "_dgst_d"}, dgst_d32, 0);
    chk({tag, "_err"}, err32, 0);
    chk({tag, "_msg_d64"}, msg_d64, 0);
    chk({tag, "_mask64"}, msk64, 0);
    chk({tag, "_dgst_vld64"}, dgst_vld64, 0);
  endtask

  // Core ready generator: held low, held high, or random per cycle.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin msg_rdy32 = 1'b0; msg_rdy64 = 1'b0; end
      1: begin msg_rdy32 = 1'b1; msg_rdy64 = 1'b1; end
      default: begin
        msg_rdy32 = 1'($urandom_range(0, 1));
        msg_rdy64 = 1'($urandom_range(0, 1));
      end
    endcase
  end

  // Word monitor for the 32-bit instance: scoreboard order and hold stability.
  logic        hold32;
  logic [31:0] pd32;
  logic [3:0]  pm32;
  logic        pl32;
  exp_t        m32;
  always @(negedge clk) begin
    if (rst) begin
      hold32 <= 1'b0;
    end else begin
      if (hold32) begin
        chk("msg32_hold_d", msg_d32, pd32);
        chk("msg32_hold_m", msk32, pm32);
        chk("msg32_hold_l", msg_lst32, pl32);
      end
      if (msg_vld32 && msg_rdy32) begin
        n_assert++;
        assert (e32_q.size() > 0) else begin
          n_fail++;
          $error("FAIL msg32_extra: observed word %h expected none", msg_d32);
        end
        if (e32_q.size() > 0) begin
          m32 = e32_q.pop_front();
          chk("msg32_d", msg_d32, m32.d);
          chk("msg32_mask", msk32, m32.m);
          chk("msg32_lst", msg_lst32, m32.l);
        end
      end
      hold32 <= msg_vld32 && !msg_rdy32;
      pd32   <= msg_d32;
      pm32   <= msk32;
      pl32   <= msg_lst32;
    end
  end

  // Word monitor for the 64-bit instance.
  exp_t m64;
  always @(negedge clk) begin
    if (!rst && msg_vld64 && msg_rdy64) begin
      n_assert++;
      assert (e64_q.size() > 0) else begin
        n_fail++;
        $error("FAIL msg64_extra: observed word %h expected none", msg_d64);
      end
      if (e64_q.size() > 0) begin
        m64 = e64_q.pop_front();
        chk("msg64_d", msg_d64, m64.d);
        chk("msg64_mask", msk64, m64.m);
        chk("msg64_lst", msg_lst64, m64.l);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int stopped;
    logic [255:0] dg;

    rst = 1'b1; byte_d = 8'h0; byte_vld = 1'b0; byte_lst = 1'b0;
    res_d = '0; res_vld = 1'b0; dgst_rdy = 1'b0; rdy_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst_in");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("rst_out");
    @(posedge clk); #1;

    // "abc" with known digest, toggling host ready
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    model_push();
    send_range(0, 3, 20, sent);
    chk("abc_sent", sent, 3);
    @(negedge clk);
    chk("abc_msg_vld_n1", msg_vld32, 1);
    chk("abc_byte_rdy_wait", byte_rdy, 0);
    @(posedge clk); #1;
    dg = {32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
          32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
    pulse_res(dg);
    get_digest(dg, 0, 8, stopped);
    chk("abc_err", err32, 0);

    // digest pulse while loading is flagged and ignored
    res_d = {8{$urandom}};
    res_vld = 1'b1;
    @(posedge clk); #1;
    res_vld = 1'b0;
    @(negedge clk);
    chk("load_res_err", err32, 1);
    chk("load_res_no_dgst", dgst_vld32, 0);
    chk("load_res_byte_rdy", byte_rdy, 1);
    @(posedge clk); #1;

    // 00..07: explicit head words while the core is stalled
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    msg_q.delete();
    for (int i = 0; i < 8; i++) msg_q.push_back(8'(i));
    model_push();
    send_range(0, 8, 20, sent);
    chk("seq8_sent", sent, 8);
    @(negedge clk);
    chk("seq8_w32_d", msg_d32, 64'h00010203);
    chk("seq8_w32_m", msk32, 4'hF);
    chk("seq8_w32_l", msg_lst32, 0);
    chk("seq8_w64_d", msg_d64, 64'h0001020304050607);
    chk("seq8_w64_m", msk64, 8'hFF);
    chk("seq8_w64_l", msg_lst64, 1);
    chk("seq8_err_sticky", err32, 1);
    rdy_mode = 1;
    @(posedge clk); #1;
    dg = {8{$urandom}};
    pulse_res(dg);
    get_digest(dg, 1, 8, stopped);

    // 40 bytes against a stalled core: FIFO fills after 32
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    rand_msg(40);
    model_push();
    send_range(0, 40, 20, sent);
    chk("full_accepted", sent, 32);
    @(negedge clk);
    chk("full_byte_rdy", byte_rdy, 0);
    chk("full_msg_vld", msg_vld32, 1);
    @(posedge clk); #1;
    rdy_mode = 2;
    send_range(32, 40, 60, sent);
    chk("full_rest", sent, 8);
    dg = {8{$urandom}};
    pulse_res(dg);
    get_digest(dg, 1, 8, stopped);

    // reset in the middle of the word-3 transfer
    rdy_mode = 1;
    rand_msg(5);
    model_push();
    send_range(0, 5, 20, sent);
    chk("rstmid_sent", sent, 5);
    dg = {8{$urandom}};
    pulse_res(dg);
    get_digest(dg, 0, 3, stopped);
    chk("rstmid_reached_w3", stopped, 1);
    rst = 1'b1;
    #1;
    reset_checks("rst_async");
    dgst_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("rst_after");
    chk("rst_no_pending32", e32_q.size(), 0);
    @(posedge clk); #1;

    // randomized messages with random core/host backpressure
    rdy_mode = 2;
    for (int m = 0; m < 6; m++) begin
      rand_msg($urandom_range(1, 20));
      model_push();
      send_range(0, msg_q.size(), 60, sent);
      chk("rand_sent", sent, msg_q.size());
      dg = {8{$urandom}};
      pulse_res(dg);
      get_digest(dg, 1, 8, stopped);
    end

    chk("final_err", err32, 0);
    chk("final_q32_empty", e32_q.size(), 0);
    chk("final_q64_empty", e64_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
